// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - multi-port register file with streamed register dump
module regfile_dump #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_last
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  logic [XLEN-1:0] regs [NREGS];

  logic wr_en;
  logic beat_fire;

  assign wr_en     = we && (waddr != '0);
  assign beat_fire = dump_valid && dump_ready;

  // Register array update: reset clears everything and wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational read ports; index 0 is forced to zero ahead of forwarding
  // so a discarded write to r0 can never leak through the bypass.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ridx;
    logic          fwd;

    assign ridx = raddr[p*AW +: AW];
    assign fwd  = (BYPASS != 0) && we && (ridx == waddr);
    assign rdata[p*XLEN +: XLEN] = (ridx == '0) ? '0 :
                                   fwd          ? wdata :
                                                  regs[ridx];
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dump FSM next state: start only from IDLE, leave RUN after the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dump_start) state_nxt = ST_RUN;
      ST_RUN:  if (beat_fire && (dump_idx == LAST_IDX)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dump FSM outputs.
  always_comb begin
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    if (state == ST_RUN) begin
      dump_valid = 1'b1;
      dump_busy  = 1'b1;
    end
  end

  assign dump_last = dump_valid && (dump_idx == LAST_IDX);

  // Dump index: steps on each accepted beat, returns to 0 after the last one
  // and is held at 0 whenever the stream is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_idx <= '0;
    end else if (state == ST_RUN) begin
      if (beat_fire) begin
        dump_idx <= (dump_idx == LAST_IDX) ? '0 : dump_idx + 1'b1;
      end
    end else begin
      dump_idx <= '0;
    end
  end

  // Dump data reflects live contents; a write to the presented index shows up
  // the cycle after it lands, with no forwarding on this path.
  assign dump_data = regs[dump_idx];

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed self-checking bench for regfile_dump
module tb_regfile_dump;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                dump_start;
  logic                dump_busy;
  logic                dump_valid;
  logic                dump_ready;
  logic [AW-1:0]       dump_idx;
  logic [XLEN-1:0]     dump_data;
  logic                dump_last;

  logic [NRD*XLEN-1:0] nb_rdata;
  logic                nb_dump_busy;
  logic                nb_dump_valid;
  logic [AW-1:0]       nb_dump_idx;
  logic [XLEN-1:0]     nb_dump_data;
  logic                nb_dump_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] model [NREGS];

  always #5 clk = ~clk;

  regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

  regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_nb (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (nb_rdata),
    .dump_start (dump_start),
    .dump_busy  (nb_dump_busy),
    .dump_valid (nb_dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (nb_dump_idx),
    .dump_data  (nb_dump_data),
    .dump_last  (nb_dump_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_raddr(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    int  exp_idx;
    bit  done;
    bit  wrote;
    logic [XLEN-1:0] vals [6];

    vals[0] = 32'd2; vals[1] = 32'd4; vals[2] = 32'd2;
    vals[3] = 32'd2; vals[4] = 32'd6; vals[5] = 32'd4;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    // Reset with a simultaneous write and dump request, both overridden.
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    dump_start = 1'b1; dump_ready = 1'b0; raddr = '0;
    tick();
    tick();
    rst = 1'b0; we = 1'b0; dump_start = 1'b0;
    set_raddr(5, 0);
    settle();
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_busy",  {31'd0, dump_busy},  32'd0);
    chk("rst_last",  {31'd0, dump_last},  32'd0);
    chk("rst_idx",   {27'd0, dump_idx},   32'd0);
    chk("rst_data",  dump_data,           32'd0);
    chk("rst_r5",    rdata[31:0],         32'd0);
    chk("rst_r0",    rdata[63:32],        32'd0);

    // Basic writes r1..r6.
    for (int i = 1; i <= 6; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = vals[i-1];
      model[i] = vals[i-1];
      tick();
    end
    we = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_raddr(i, i);
      settle();
      chk($sformatf("rd_p0_r%0d", i), rdata[31:0],  vals[i-1]);
      chk($sformatf("rd_p1_r%0d", i), rdata[63:32], vals[i-1]);
    end
    set_raddr(2, 5);
    settle();
    chk("rd_mix_p0", rdata[31:0],  32'd4);
    chk("rd_mix_p1", rdata[63:32], 32'd6);

    // Write to r0 is discarded, also on the bypass path.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    set_raddr(0, 0);
    settle();
    chk("r0_same_cycle", rdata[31:0], 32'd0);
    tick();
    we = 1'b0;
    settle();
    chk("r0_after_p0", rdata[31:0],  32'd0);
    chk("r0_after_p1", rdata[63:32], 32'd0);

    // Forwarding with BYPASS=1 versus old value with BYPASS=0.
    we = 1'b1; waddr = 5'd7; wdata = 32'h55;
    set_raddr(7, 1);
    settle();
    chk("byp_on_p0",  rdata[31:0],    32'h55);
    chk("byp_off_p0", nb_rdata[31:0], 32'h0);
    chk("byp_on_p1",  rdata[63:32],   32'd2);
    tick();
    model[7] = 32'h55;
    we = 1'b0;
    settle();
    chk("byp_on_after",  rdata[31:0],    32'h55);
    chk("byp_off_after", nb_rdata[31:0], 32'h55);

    // Full dump with ready held high.
    dump_ready = 1'b1; dump_start = 1'b1;
    settle();
    chk("idle_valid", {31'd0, dump_valid}, 32'd0);
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      settle();
      chk($sformatf("d1_valid_%0d", k), {31'd0, dump_valid}, 32'd1);
      chk($sformatf("d1_busy_%0d", k),  {31'd0, dump_busy},  32'd1);
      chk($sformatf("d1_idx_%0d", k),   {27'd0, dump_idx},   k);
      chk($sformatf("d1_data_%0d", k),  dump_data,           model[k]);
      chk($sformatf("d1_last_%0d", k),  {31'd0, dump_last},  (k == NREGS-1) ? 32'd1 : 32'd0);
      chk($sformatf("d1_nb_idx_%0d", k), {27'd0, nb_dump_idx}, k);
      tick();
    end
    settle();
    chk("d1_end_busy",  {31'd0, dump_busy},  32'd0);
    chk("d1_end_valid", {31'd0, dump_valid}, 32'd0);
    chk("d1_end_last",  {31'd0, dump_last},  32'd0);
    chk("d1_end_idx",   {27'd0, dump_idx},   32'd0);

    // Stalling dump with dump_start held high; r9 written before it is shown.
    dump_start = 1'b1;
    tick();
    exp_idx = 0; done = 1'b0; wrote = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      dump_ready = 1'($urandom_range(0, 1));
      if (exp_idx == 3 && !wrote) begin
        we = 1'b1; waddr = 5'd9; wdata = 32'hAB;
        wrote = 1'b1;
      end
      settle();
      chk("d2_valid", {31'd0, dump_valid}, 32'd1);
      chk("d2_idx",   {27'd0, dump_idx},   exp_idx);
      chk("d2_data",  dump_data,           model[exp_idx]);
      chk("d2_last",  {31'd0, dump_last},  (exp_idx == NREGS-1) ? 32'd1 : 32'd0);
      if (dump_ready) begin
        if (exp_idx == NREGS-1) done = 1'b1;
        else exp_idx++;
      end
      tick();
      if (we) model[9] = 32'hAB;
      we = 1'b0;
    end
    chk("d2_done", {31'd0, done}, 32'd1);
    dump_ready = 1'b1;
    settle();
    chk("d2_gap_busy", {31'd0, dump_busy}, 32'd0);
    set_raddr(9, 0);
    settle();
    chk("d2_r9", rdata[31:0], 32'hAB);
    tick();
    settle();
    chk("d3_restart_busy", {31'd0, dump_busy}, 32'd1);
    chk("d3_restart_idx",  {27'd0, dump_idx},  32'd0);
    dump_start = 1'b0;

    // Reset in the middle of a dump at index 12.
    for (int k = 0; k < 12; k++) tick();
    settle();
    chk("d3_idx12", {27'd0, dump_idx}, 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("abort_valid", {31'd0, dump_valid}, 32'd0);
    chk("abort_busy",  {31'd0, dump_busy},  32'd0);
    chk("abort_idx",   {27'd0, dump_idx},   32'd0);
    for (int i = 0; i < NREGS; i++) begin
      set_raddr(i, NREGS - 1 - i);
      settle();
      chk($sformatf("abort_p0_r%0d", i), rdata[31:0],  32'd0);
      chk($sformatf("abort_p1_r%0d", i), rdata[63:32], 32'd0);
    end
    tick();
    settle();
    chk("abort_stay_valid", {31'd0, dump_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
